// File: rtl/sync_modn_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The controller (master) drives count/load requests; the counter (slave) returns q and the event flags.
interface sync_modn_updown_counter_if #(
  parameter int unsigned WIDTH = 5
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up, load, load_value,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_value,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/sync_modn_updown_counter.sv
// Single-clock modulo-N up/down counter with parallel load and a combinational
// terminal-count carry so that cascaded digits advance on the same edge.
module sync_modn_updown_counter #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MODULUS = 10
) (
  input  logic                         clk,
  input  logic                         clear,
  sync_modn_updown_counter_if.slave    bus
);

  localparam longint unsigned SPAN    = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  // Reject moduli the register cannot represent.
  if (MODULUS < 2 || 64'(MODULUS) > SPAN) begin : g_bad_modulus
    $error("sync_modn_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             load_err_r;
  logic             load_err_nxt;
  logic             at_top;
  logic             at_zero;
  logic             q_out_of_range;
  logic             load_in_range;

  // Terminal-value decode shared by next-state and carry logic.
  always_comb begin
    at_top         = (q_r == TOP);
    at_zero        = (q_r == '0);
    q_out_of_range = ({1'b0, q_r} >= MOD_EXT);
    load_in_range  = ({1'b0, bus.load_value} < MOD_EXT);
  end

  // Next-state: load beats count; hold otherwise. Flags default low so they pulse.
  always_comb begin
    q_nxt        = q_r;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (bus.load) begin
      if (load_in_range) begin
        q_nxt = bus.load_value;
      end else begin
        q_nxt        = TOP;
        load_err_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (q_out_of_range) begin
        // Unreachable in normal operation; recover to a legal count.
        q_nxt    = '0;
        wrap_nxt = 1'b1;
      end else if (bus.up) begin
        if (at_top) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_nxt    = TOP;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  // State register; clear has top priority.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_r        <= '0;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_nxt;
      wrap_r     <= wrap_nxt;
      load_err_r <= load_err_nxt;
    end
  end

  assign bus.q        = q_r;
  assign bus.wrap     = wrap_r;
  assign bus.load_err = load_err_r;
  // Carry is combinational so the next digit sees it before the same edge.
  assign bus.tc       = bus.en & ((bus.up & at_top) | (~bus.up & at_zero));

endmodule

// File: tb/tb_sync_modn_updown_counter.sv
// Scoreboard bench: stimulus pushes model predictions, monitors pop and compare.
module tb_sync_modn_updown_counter;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  sync_modn_updown_counter_if #(.WIDTH(5)) bus0 ();
  sync_modn_updown_counter_if #(.WIDTH(5)) bus1 ();
  sync_modn_updown_counter_if #(.WIDTH(3)) bus2 ();

  sync_modn_updown_counter #(.WIDTH(5), .MODULUS(10)) dut0 (.clk(clk), .clear(clear), .bus(bus0));
  sync_modn_updown_counter #(.WIDTH(5), .MODULUS(10)) dut1 (.clk(clk), .clear(clear), .bus(bus1));
  sync_modn_updown_counter #(.WIDTH(3), .MODULUS(8))  dut2 (.clk(clk), .clear(clear), .bus(bus2));

  // Tens digit of a two-digit decade chain.
  assign bus1.en         = bus0.tc;
  assign bus1.up         = 1'b1;
  assign bus1.load       = 1'b0;
  assign bus1.load_value = '0;

  typedef struct { int q0; bit w0; bit e0; int q2; bit w2; bit e2; } st_exp_t;
  typedef struct { bit tc0; bit tc2; } tc_exp_t;
  typedef struct { int val; bit w1; } casc_exp_t;

  st_exp_t   st_q[$];
  tc_exp_t   tc_q[$];
  casc_exp_t casc_q[$];

  int checks = 0;
  int passes = 0;
  int m0 = 0;
  int m2 = 0;
  int cnt = 0;
  bit casc_on = 1'b0;
  int wrap1_seen = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Reference behaviour expressed with modular arithmetic.
  function automatic void model_step(int md, int cur, bit clr, bit ld, int lv, bit en, bit up,
                                     output int nq, output bit wr, output bit le);
    nq = cur; wr = 1'b0; le = 1'b0;
    if (clr) nq = 0;
    else if (ld) begin
      if (lv < md) nq = lv;
      else begin nq = md - 1; le = 1'b1; end
    end else if (en) begin
      if (up) begin nq = (cur + 1) % md; wr = (nq == 0); end
      else begin nq = (cur + md - 1) % md; wr = (cur == 0); end
    end
  endfunction

  task automatic drive(bit clr, bit ld, int lv, bit en, bit up);
    st_exp_t   s;
    tc_exp_t   t;
    casc_exp_t c;
    @(negedge clk);
    clear = clr;
    bus0.load = ld; bus0.load_value = 5'(lv); bus0.en = en; bus0.up = up;
    bus2.load = ld; bus2.load_value = 3'(lv); bus2.en = en; bus2.up = up;
    t.tc0 = en && (up ? (m0 == 9) : (m0 == 0));
    t.tc2 = en && (up ? (m2 == 7) : (m2 == 0));
    tc_q.push_back(t);
    model_step(10, m0, clr, ld, lv % 32, en, up, s.q0, s.w0, s.e0);
    model_step(8,  m2, clr, ld, lv % 8,  en, up, s.q2, s.w2, s.e2);
    st_q.push_back(s);
    m0 = s.q0; m2 = s.q2;
    if (casc_on) begin
      c.w1  = !clr && (cnt == 99);
      c.val = clr ? 0 : (cnt + 1) % 100;
      casc_q.push_back(c);
      cnt = c.val;
    end
  endtask

  // Registered outputs, sampled just after the active edge.
  initial begin
    st_exp_t   s;
    casc_exp_t c;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("q0", int'(bus0.q), s.q0);
        chk("wrap0", int'(bus0.wrap), int'(s.w0));
        chk("load_err0", int'(bus0.load_err), int'(s.e0));
        chk("q2", int'(bus2.q), s.q2);
        chk("wrap2", int'(bus2.wrap), int'(s.w2));
        chk("load_err2", int'(bus2.load_err), int'(s.e2));
      end
      if (casc_q.size() > 0) begin
        c = casc_q.pop_front();
        chk("cascade_val", 10 * int'(bus1.q) + int'(bus0.q), c.val);
        chk("wrap1", int'(bus1.wrap), int'(c.w1));
        if (bus1.wrap) wrap1_seen++;
      end
    end
  end

  // Combinational carry, sampled after new inputs settle mid-cycle.
  initial begin
    tc_exp_t t;
    forever begin
      @(negedge clk);
      #1;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        chk("tc0", int'(bus0.tc), int'(t.tc0));
        chk("tc2", int'(bus2.tc), int'(t.tc2));
      end
    end
  end

  initial begin
    clear = 1'b1;
    bus0.load = 1'b0; bus0.load_value = '0; bus0.en = 1'b0; bus0.up = 1'b1;
    bus2.load = 1'b0; bus2.load_value = '0; bus2.en = 1'b0; bus2.up = 1'b1;

    // Reset then count up through a wrap.
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    repeat (12) drive(0, 0, 0, 1, 1);
    // Down through zero.
    drive(0, 1, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 0);
    // Load priority and clamped load.
    drive(0, 1, 7, 1, 1);
    drive(0, 1, 23, 1, 1);
    drive(0, 0, 0, 1, 0);
    // Clear beats load.
    drive(0, 1, 5, 0, 1);
    drive(1, 1, 3, 1, 1);
    // Hold with toggling direction.
    drive(0, 1, 4, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1'(i));

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    // Two-digit decade chain 00..99..00.
    casc_on = 1'b1;
    drive(1, 0, 0, 0, 1);
    repeat (100) drive(0, 0, 0, 1, 1);
    casc_on = 1'b0;
    drive(0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #2;
    chk("drain_state", st_q.size(), 0);
    chk("drain_tc", tc_q.size(), 0);
    chk("drain_casc", casc_q.size(), 0);
    chk("wrap1_pulses", wrap1_seen, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
